lcd_driver: RTL and testbench



---
 rtl/lcd_driver.sv | 221 ++++++++++++++++++++++
 tb/tb_lcd_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_driver
// Brief    : HD44780 8-bit write-only driver: power-up init, then a
//            rdy-paced command stream decoded into bus writes or timed waits.
// Revision : 1.0
// ============================================================================
module lcd_driver #(
   parameter int EN_PULSE    = 25,
   parameter int CMD_DELAY   = 2500,
   parameter int CLR_DELAY   = 100000,
   parameter int PWR_DELAY   = 1000000,
   parameter int WAIT2_DELAY = 100000000,
   parameter int IDLE_GAP    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] DATA,
   output logic        rdy,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_EN,
   output logic [7:0]  LCD_DATA,
   output logic        init_done
);

   localparam int c_CW = 32;
   localparam logic [c_CW-1:0] c_EN         = c_CW'(EN_PULSE);
   localparam logic [c_CW-1:0] c_CMD        = c_CW'(CMD_DELAY);
   localparam logic [c_CW-1:0] c_CLR        = c_CW'(CLR_DELAY);
   localparam logic [c_CW-1:0] c_PWR        = c_CW'(PWR_DELAY);
   localparam logic [c_CW-1:0] c_SETTLE     = c_CW'(2);
   // Command-phase holds run one cycle short: the STROBE/SETTLE/DECODE
   // overhead before the next EN more than covers the LCD's busy time.
   localparam logic [c_CW-1:0] c_CMD_TAIL   = c_CW'(CMD_DELAY - 1);
   localparam logic [c_CW-1:0] c_CLR_TAIL   = c_CW'(CLR_DELAY - 1);
   localparam logic [c_CW-1:0] c_WAIT2_TAIL = c_CW'(WAIT2_DELAY - 1);
   localparam logic [c_CW-1:0] c_IDLE_TAIL  = c_CW'(IDLE_GAP - 1);

   typedef enum logic [3:0] {
      PWR_WAIT   = 4'd0,
      INIT_SETUP = 4'd1,
      INIT_EN    = 4'd2,
      INIT_HOLD  = 4'd3,
      STROBE     = 4'd4,
      SETTLE     = 4'd5,
      DECODE     = 4'd6,
      BUS_SETUP  = 4'd7,
      BUS_EN     = 4'd8,
      HOLD       = 4'd9
   } state_t;

   state_t            r_state;
   logic [c_CW-1:0]   r_count;
   logic [1:0]        r_init_idx;
   logic              r_clr;
   logic              r_rdy;
   logic              r_rs;
   logic              r_en;
   logic [7:0]        r_db;
   logic              r_init_done;

   logic [3:0]        w_opcode;
   logic [7:0]        w_payload;
   logic [7:0]        w_setad;
   logic              w_done;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h06;
         default: init_byte = 8'h01;
      endcase
   endfunction

   assign w_opcode  = DATA[11:8];
   assign w_payload = DATA[7:0];
   // A loaded count of N keeps the state for N cycles (0 behaves as 1).
   assign w_done    = (r_count <= 32'd1);

   // Linear column 0..79 folded onto the two 40-column DDRAM lines.
   always_comb begin
      w_setad = 8'h80;
      if (w_payload < 8'd40)
         w_setad = 8'h80 + w_payload;
      else if (w_payload < 8'd80)
         w_setad = w_payload + 8'h98;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= PWR_WAIT;
         r_count     <= c_PWR;
         r_init_idx  <= 2'd0;
         r_clr       <= 1'b0;
         r_rdy       <= 1'b0;
         r_rs        <= 1'b0;
         r_en        <= 1'b0;
         r_db        <= 8'h00;
         r_init_done <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         case (r_state)
            PWR_WAIT: begin
               if (w_done) begin
                  r_state <= INIT_SETUP;
                  r_rs    <= 1'b0;
                  r_db    <= init_byte(r_init_idx);
               end else begin
                  r_count <= r_count - 32'd1;
               end
            end
            INIT_SETUP: begin
               r_state <= INIT_EN;
               r_en    <= 1'b1;
               r_count <= c_EN;
            end
            INIT_EN: begin
               if (w_done) begin
                  r_state <= INIT_HOLD;
                  r_en    <= 1'b0;
                  r_count <= (r_init_idx == 2'd3) ? c_CLR : c_CMD;
               end else begin
                  r_count <= r_count - 32'd1;
               end
            end
            INIT_HOLD: begin
               if (!w_done) begin
                  r_count <= r_count - 32'd1;
               end else if (r_init_idx == 2'd3) begin
                  r_state     <= STROBE;
                  r_init_done <= 1'b1;
                  r_rdy       <= 1'b1;
               end else begin
                  r_state    <= INIT_SETUP;
                  r_init_idx <= r_init_idx + 2'd1;
                  r_db       <= init_byte(r_init_idx + 2'd1);
               end
            end
            STROBE: begin
               r_state <= SETTLE;
               r_count <= c_SETTLE;
            end
            SETTLE: begin
               if (w_done)
                  r_state <= DECODE;
               else
                  r_count <= r_count - 32'd1;
            end
            DECODE: begin
               r_state <= BUS_SETUP;
               r_clr   <= 1'b0;
               case (w_opcode)
                  4'h0: begin
                     r_rs  <= 1'b0;
                     r_db  <= 8'h01;
                     r_clr <= 1'b1;
                  end
                  4'h1: begin
                     r_rs <= 1'b1;
                     r_db <= w_payload;
                  end
                  4'h2: begin
                     r_rs <= 1'b0;
                     r_db <= 8'h40 | {2'b00, w_payload[5:0]};
                  end
                  4'h3: begin
                     r_rs <= 1'b0;
                     r_db <= w_setad;
                  end
                  4'h4: begin
                     r_state <= HOLD;
                     r_count <= c_WAIT2_TAIL;
                  end
                  default: begin
                     r_state <= HOLD;
                     r_count <= c_IDLE_TAIL;
                  end
               endcase
            end
            BUS_SETUP: begin
               r_state <= BUS_EN;
               r_en    <= 1'b1;
               r_count <= c_EN;
            end
            BUS_EN: begin
               if (w_done) begin
                  r_state <= HOLD;
                  r_en    <= 1'b0;
                  r_count <= r_clr ? c_CLR_TAIL : c_CMD_TAIL;
               end else begin
                  r_count <= r_count - 32'd1;
               end
            end
            HOLD: begin
               if (w_done) begin
                  r_state <= STROBE;
                  r_rdy   <= 1'b1;
               end else begin
                  r_count <= r_count - 32'd1;
               end
            end
            default: begin
               r_state <= PWR_WAIT;
               r_count <= c_PWR;
               r_en    <= 1'b0;
            end
         endcase
      end
   end

   assign rdy       = r_rdy;
   assign LCD_RS    = r_rs;
   assign LCD_RW    = 1'b0;
   assign LCD_EN    = r_en;
   assign LCD_DATA  = r_db;
   assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_driver
// Brief    : Randomized self-checking bench for lcd_driver against a
//            command-level timing/encoding model.
// Revision : 1.0
// ============================================================================
module tb_lcd_driver;

   localparam int EN_PULSE    = 2;
   localparam int CMD_DELAY   = 4;
   localparam int CLR_DELAY   = 8;
   localparam int PWR_DELAY   = 10;
   localparam int WAIT2_DELAY = 20;
   localparam int IDLE_GAP    = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] DATA = 12'h000;
   logic        rdy, LCD_RS, LCD_RW, LCD_EN, init_done;
   logic [7:0]  LCD_DATA;

   int n_checks = 0;
   int n_errors = 0;
   bit lost     = 1'b0;

   lcd_driver #(
      .EN_PULSE(EN_PULSE), .CMD_DELAY(CMD_DELAY), .CLR_DELAY(CLR_DELAY),
      .PWR_DELAY(PWR_DELAY), .WAIT2_DELAY(WAIT2_DELAY), .IDLE_GAP(IDLE_GAP)
   ) u_dut (
      .clk(clk), .rst(rst), .DATA(DATA), .rdy(rdy), .LCD_RS(LCD_RS),
      .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Command-level model: what the LCD bus should see and rdy-to-rdy spacing.
   function automatic void model(input logic [11:0] cmd, output bit bus, output bit rs,
                                 output logic [7:0] db, output int gap);
      int op, p;
      op  = int'(cmd[11:8]);
      p   = int'(cmd[7:0]);
      bus = 1'b1;
      rs  = 1'b0;
      db  = 8'h00;
      gap = 3 + 1 + EN_PULSE + CMD_DELAY;
      case (op)
         0: begin db = 8'h01; gap = 3 + 1 + EN_PULSE + CLR_DELAY; end
         1: begin rs = 1'b1; db = 8'(p); end
         2: db = 8'(64 + (p % 64));
         3: begin
            if (p < 40)      db = 8'(128 + p);
            else if (p < 80) db = 8'(192 + (p - 40));
            else             db = 8'h80;
         end
         4: begin bus = 1'b0; gap = 3 + WAIT2_DELAY; end
         default: begin bus = 1'b0; gap = 3 + IDLE_GAP; end
      endcase
   endfunction

   // Called at the first negedge after rst drops; returns at the first rdy.
   task automatic do_init(input string tag);
      logic [7:0] exp_db [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
      logic [7:0] dbs [4];
      int widths [4];
      int first_en = -1, n_pulse = 0, width = 0, early = 0, rs_bad = 0;
      int en_before = 0, last_en = 0, k_rdy = -1;
      for (int k = 0; k < 400; k++) begin
         if (k > 0) step();
         if (rdy && !init_done) early++;
         if (k < PWR_DELAY && LCD_EN) en_before++;
         if (LCD_EN) begin
            if (width == 0) begin
               if (first_en < 0) first_en = k;
               if (n_pulse < 4) dbs[n_pulse] = LCD_DATA;
            end
            if (LCD_RS) rs_bad++;
            width++;
            last_en = k;
         end else if (width > 0) begin
            if (n_pulse < 4) widths[n_pulse] = width;
            n_pulse++;
            width = 0;
         end
         if (rdy) begin
            k_rdy = k;
            break;
         end
      end
      check({tag, " rdy_timeout"}, 32'(k_rdy >= 0), 32'd1);
      if (k_rdy < 0) begin
         lost = 1'b1;
         return;
      end
      check({tag, " en_during_pwr"}, en_before, 0);
      check({tag, " first_en_cycle"}, first_en, PWR_DELAY + 1);
      check({tag, " pulse_count"}, n_pulse, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s db%0d", tag, i), dbs[i], exp_db[i]);
         check($sformatf("%s width%0d", tag, i), widths[i], EN_PULSE);
      end
      check({tag, " rs_low"}, rs_bad, 0);
      check({tag, " rdy_early"}, early, 0);
      check({tag, " init_done"}, init_done, 1'b1);
      check({tag, " clr_hold"}, k_rdy - last_en, CLR_DELAY + 1);
   endtask

   // Called at a negedge with rdy high; plays the sequencer for one command.
   task automatic run_cmd(input logic [11:0] cmd);
      bit bus, rs;
      logic [7:0] db, db_en, prev_db;
      logic rs_en, prev_rs, rdy_k1;
      int gap, en_n = 0, gap_seen = -1, setup_bad = 0, stable_bad = 0;
      string tag;
      if (lost) return;
      tag = $sformatf("cmd %03h", cmd);
      model(cmd, bus, rs, db, gap);
      DATA    = 12'($urandom);
      prev_db = LCD_DATA;
      prev_rs = LCD_RS;
      rdy_k1  = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (k == 1) rdy_k1 = rdy;
         if (k == 2) DATA = cmd;
         if (k == 4) DATA = 12'($urandom);
         if (LCD_EN) begin
            if (en_n == 0) begin
               db_en = LCD_DATA;
               rs_en = LCD_RS;
               if (prev_db !== LCD_DATA || prev_rs !== LCD_RS) setup_bad++;
            end else if (LCD_DATA !== db_en || LCD_RS !== rs_en) begin
               stable_bad++;
            end
            en_n++;
         end else if (en_n > 0 && (LCD_DATA !== db_en || LCD_RS !== rs_en)) begin
            stable_bad++;
         end
         prev_db = LCD_DATA;
         prev_rs = LCD_RS;
         if (rdy) begin
            gap_seen = k;
            break;
         end
      end
      check({tag, " rdy_gap"}, gap_seen, gap);
      if (gap_seen < 0) lost = 1'b1;
      check({tag, " rdy_one_cycle"}, rdy_k1, 1'b0);
      check({tag, " rw"}, LCD_RW, 1'b0);
      if (bus) begin
         check({tag, " en_width"}, en_n, EN_PULSE);
         check({tag, " db"}, db_en, db);
         check({tag, " rs"}, rs_en, rs);
         check({tag, " setup"}, setup_bad, 0);
         check({tag, " stable"}, stable_bad, 0);
      end else begin
         check({tag, " no_en"}, en_n, 0);
      end
   endtask

   function automatic logic [11:0] rand_cmd();
      logic [3:0] op;
      case ($urandom_range(0, 9))
         0:       op = 4'h0;
         1, 2:    op = 4'h1;
         3:       op = 4'h2;
         4, 5:    op = 4'h3;
         6:       op = 4'h4;
         7:       op = 4'hF;
         default: op = 4'($urandom_range(5, 14));
      endcase
      return {op, 8'($urandom)};
   endfunction

   initial begin
      logic [11:0] directed [13] = '{12'h141, 12'h328, 12'h304, 12'h363, 12'h327,
                                     12'h34F, 12'h350, 12'h2FF, 12'h400, 12'hF00,
                                     12'h700, 12'h000, 12'h1FF};
      bit saw_en;
      rst  = 1'b1;
      DATA = 12'h000;
      repeat (3) step();
      check("reset rdy", rdy, 1'b0);
      check("reset en", LCD_EN, 1'b0);
      check("reset rs", LCD_RS, 1'b0);
      check("reset rw", LCD_RW, 1'b0);
      check("reset db", LCD_DATA, 8'h00);
      check("reset init_done", init_done, 1'b0);

      rst = 1'b0;
      do_init("init");
      foreach (directed[i]) run_cmd(directed[i]);
      for (int i = 0; i < 25; i++) run_cmd(rand_cmd());

      if (!lost) begin
         DATA   = 12'h141;
         saw_en = 1'b0;
         for (int k = 0; k < 50; k++) begin
            step();
            if (LCD_EN) begin
               saw_en = 1'b1;
               break;
            end
         end
         check("midwrite en_seen", saw_en, 1'b1);
         rst = 1'b1;
         step();
         check("midwrite en_cut", LCD_EN, 1'b0);
         check("midwrite init_done", init_done, 1'b0);
         check("midwrite rdy", rdy, 1'b0);
         rst = 1'b0;
         do_init("reinit");
         run_cmd(12'h141);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
